// File: rtl/pc_lut_writer.sv
// pc_lut_writer: byte-stream loader for the fetch-stage branch-target LUT.
// Assembles a shadow table, verifies an XOR checksum, commits atomically.
module pc_lut_writer #(
    parameter int PC_WIDTH = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic                abort,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    input  logic [3:0]          index,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int LUT_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE,
        RECV_LO,
        RECV_HI,
        CHECK
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          ptr;
    logic [7:0]          csum;
    logic [7:0]          lo;
    logic                done_q;
    logic                err_q;
    logic [PC_WIDTH-1:0] shadow [LUT_SIZE];
    logic [PC_WIDTH-1:0] active [LUT_SIZE];
    logic                take;

    assign byte_ready = (state != IDLE);
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign next_pc    = active[index];

    // abort wins over a same-cycle byte, which is then left unconsumed
    assign take = byte_valid & byte_ready & ~abort;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = RECV_LO;
                end
            end
            RECV_LO: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (take) begin
                    state_next = RECV_HI;
                end
            end
            RECV_HI: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (take) begin
                    state_next = (ptr == 4'd15) ? CHECK : RECV_LO;
                end
            end
            CHECK: begin
                if (abort || take) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // datapath: pointer, checksum, shadow assembly and atomic commit
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            csum   <= '0;
            lo     <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < LUT_SIZE; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        ptr   <= '0;
                        csum  <= '0;
                        err_q <= 1'b0;
                    end
                end
                RECV_LO: begin
                    if (take) begin
                        lo   <= byte_data;
                        csum <= csum ^ byte_data;
                    end
                end
                RECV_HI: begin
                    if (take) begin
                        shadow[ptr] <= {byte_data[PC_WIDTH-9:0], lo};
                        csum        <= csum ^ byte_data;
                        if (ptr != 4'd15) begin
                            ptr <= ptr + 4'd1;
                        end
                    end
                end
                CHECK: begin
                    if (take) begin
                        if (byte_data == csum) begin
                            active <= shadow;
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
